cpu_axi_rd_arbiter: RTL and testbench

Shares one AXI4 read port to memory between the CPU instruction-fetch read master and the data read master. Requests are granted round-robin, one burst at a time. Each AR request is registered toward memory, and the R channel is steered back to the granted master until the last beat. A sticky status bit flags bursts whose `rlast` position disagrees with the requested `arlen`.

---
 rtl/cpu_axi_rd_arbiter.sv | 137 +++++++++++++
 tb/tb_cpu_axi_rd_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_axi_rd_arbiter.sv
// Round-robin arbiter sharing one AXI4 read port between the instruction-fetch
// and data read masters. One burst is outstanding at a time; R beats are steered combinationally.
module cpu_axi_rd_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  system_clk,
  input  logic                  system_reset,

  input  logic [ADDR_WIDTH-1:0] inst_araddr,
  input  logic [7:0]            inst_arlen,
  input  logic                  inst_arvalid,
  output logic                  inst_arready,
  output logic [DATA_WIDTH-1:0] inst_rdata,
  output logic [1:0]            inst_rresp,
  output logic                  inst_rlast,
  output logic                  inst_rvalid,
  input  logic                  inst_rready,

  input  logic [ADDR_WIDTH-1:0] data_araddr,
  input  logic [7:0]            data_arlen,
  input  logic                  data_arvalid,
  output logic                  data_arready,
  output logic [DATA_WIDTH-1:0] data_rdata,
  output logic [1:0]            data_rresp,
  output logic                  data_rlast,
  output logic                  data_rvalid,
  input  logic                  data_rready,

  output logic [ADDR_WIDTH-1:0] mem_araddr,
  output logic [7:0]            mem_arlen,
  output logic                  mem_arvalid,
  input  logic                  mem_arready,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic [1:0]            mem_rresp,
  input  logic                  mem_rlast,
  input  logic                  mem_rvalid,
  output logic                  mem_rready,

  output logic                  grant_data,
  output logic                  len_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;

  logic [1:0]            r_state;
  logic                  r_prio;       // 1 = data wins the next tie
  logic                  r_grant;      // 1 = data owns the port
  logic [ADDR_WIDTH-1:0] r_araddr;
  logic [7:0]            r_arlen;
  logic [7:0]            r_beat_cnt;
  logic                  r_len_err;

  logic w_idle;
  logic w_in_data;
  logic w_gnt_inst;
  logic w_gnt_data;
  logic w_to_inst;
  logic w_to_data;
  logic w_beat;

  assign w_idle    = (r_state == S_IDLE);
  assign w_in_data = (r_state == S_DATA);

  assign w_gnt_inst = w_idle && inst_arvalid && (!data_arvalid || !r_prio);
  assign w_gnt_data = w_idle && data_arvalid && (!inst_arvalid ||  r_prio);

  assign inst_arready = w_gnt_inst;
  assign data_arready = w_gnt_data;

  assign mem_araddr  = r_araddr;
  assign mem_arlen   = r_arlen;
  assign mem_arvalid = (r_state == S_ADDR);
  assign grant_data  = r_grant;
  assign len_err     = r_len_err;

  // Steering is gated by state so an abandoned burst never leaks beats after reset.
  assign w_to_inst  = w_in_data && !r_grant;
  assign w_to_data  = w_in_data &&  r_grant;
  assign mem_rready = (w_to_inst && inst_rready) || (w_to_data && data_rready);
  assign w_beat     = mem_rvalid && mem_rready;

  assign inst_rvalid = w_to_inst && mem_rvalid;
  assign inst_rdata  = w_to_inst ? mem_rdata : '0;
  assign inst_rresp  = w_to_inst ? mem_rresp : 2'b00;
  assign inst_rlast  = w_to_inst && mem_rlast;

  assign data_rvalid = w_to_data && mem_rvalid;
  assign data_rdata  = w_to_data ? mem_rdata : '0;
  assign data_rresp  = w_to_data ? mem_rresp : 2'b00;
  assign data_rlast  = w_to_data && mem_rlast;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge system_clk) begin
    if (system_reset) begin
      r_state    <= S_IDLE;
      r_prio     <= 1'b0;
      r_grant    <= 1'b0;
      r_araddr   <= '0;
      r_arlen    <= 8'd0;
      r_beat_cnt <= 8'd0;
      r_len_err  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_gnt_inst || w_gnt_data) begin
            r_araddr   <= w_gnt_data ? data_araddr : inst_araddr;
            r_arlen    <= w_gnt_data ? data_arlen  : inst_arlen;
            r_grant    <= w_gnt_data;
            r_beat_cnt <= 8'd0;
            r_state    <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (mem_arready) r_state <= S_DATA;
        end
        S_DATA: begin
          if (w_beat) begin
            r_beat_cnt <= r_beat_cnt + 8'd1;
            // r_beat_cnt is the index of the current beat; it must equal arlen exactly on rlast.
            if (mem_rlast) begin
              if (r_beat_cnt != r_arlen) r_len_err <= 1'b1;
              r_prio  <= ~r_grant;
              r_state <= S_IDLE;
            end else if (r_beat_cnt == r_arlen) begin
              r_len_err <= 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_axi_rd_arbiter.sv
// Self-checking bench for cpu_axi_rd_arbiter: directed scenarios then random bursts,
// checked against a transaction-level model of the arbitration and length rules.
module tb_cpu_axi_rd_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          system_clk = 1'b0;
  logic          system_reset;
  logic [AW-1:0] inst_araddr, data_araddr, mem_araddr;
  logic [7:0]    inst_arlen, data_arlen, mem_arlen;
  logic          inst_arvalid, inst_arready, data_arvalid, data_arready;
  logic [DW-1:0] inst_rdata, data_rdata, mem_rdata;
  logic [1:0]    inst_rresp, data_rresp, mem_rresp;
  logic          inst_rlast, data_rlast, mem_rlast;
  logic          inst_rvalid, data_rvalid, mem_rvalid;
  logic          inst_rready, data_rready, mem_rready;
  logic          mem_arvalid, mem_arready;
  logic          grant_data, len_err;

  cpu_axi_rd_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .system_clk(system_clk), .system_reset(system_reset),
    .inst_araddr(inst_araddr), .inst_arlen(inst_arlen), .inst_arvalid(inst_arvalid),
    .inst_arready(inst_arready), .inst_rdata(inst_rdata), .inst_rresp(inst_rresp),
    .inst_rlast(inst_rlast), .inst_rvalid(inst_rvalid), .inst_rready(inst_rready),
    .data_araddr(data_araddr), .data_arlen(data_arlen), .data_arvalid(data_arvalid),
    .data_arready(data_arready), .data_rdata(data_rdata), .data_rresp(data_rresp),
    .data_rlast(data_rlast), .data_rvalid(data_rvalid), .data_rready(data_rready),
    .mem_araddr(mem_araddr), .mem_arlen(mem_arlen), .mem_arvalid(mem_arvalid),
    .mem_arready(mem_arready), .mem_rdata(mem_rdata), .mem_rresp(mem_rresp),
    .mem_rlast(mem_rlast), .mem_rvalid(mem_rvalid), .mem_rready(mem_rready),
    .grant_data(grant_data), .len_err(len_err)
  );

  always #5 system_clk = ~system_clk;

  int total = 0;
  int bad   = 0;

  // Transaction-level model: pending requests per master (0 = inst, 1 = data),
  // the master that wins the next tie, and the sticky length-error flag.
  bit          req [2];
  logic [31:0] addr [2];
  logic [7:0]  len [2];
  int          nb [2];
  int          m_prio;
  bit          m_err;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge system_clk);
    #1;
  endtask

  task automatic drive_idle();
    inst_arvalid = 1'b0; data_arvalid = 1'b0;
    inst_araddr = '0; data_araddr = '0; inst_arlen = '0; data_arlen = '0;
    inst_rready = 1'b0; data_rready = 1'b0;
    mem_arready = 1'b0; mem_rvalid = 1'b0; mem_rlast = 1'b0;
    mem_rdata = '0; mem_rresp = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    #1;
    check({tag, "_mem_arvalid"}, mem_arvalid, 0);
    check({tag, "_mem_araddr"},  mem_araddr, 0);
    check({tag, "_mem_arlen"},   mem_arlen, 0);
    check({tag, "_len_err"},     len_err, 0);
    check({tag, "_grant_data"},  grant_data, 0);
    check({tag, "_inst_rvalid"}, inst_rvalid, 0);
    check({tag, "_data_rvalid"}, data_rvalid, 0);
    check({tag, "_mem_rready"},  mem_rready, 0);
  endtask

  task automatic do_reset();
    drive_idle();
    system_reset = 1'b1;
    req[0] = 0; req[1] = 0;
    m_prio = 0; m_err = 0;
    step(); step();
    system_reset = 1'b0;
  endtask

  // One complete arbitration + burst. abort_at >= 0 asserts reset after that many beats.
  task automatic burst(input int ar_delay, input bit toggle, input int abort_at);
    int w, sent, cyc;
    bit rr, lastb, aborted;
    logic [31:0] d;
    logic [1:0]  rs;
    inst_arvalid = req[0]; inst_araddr = addr[0]; inst_arlen = len[0];
    data_arvalid = req[1]; data_araddr = addr[1]; data_arlen = len[1];
    mem_rvalid = 1'b0; mem_arready = 1'b0;
    #1;
    w = (req[0] && req[1]) ? m_prio : (req[1] ? 1 : 0);
    check("arready_inst", inst_arready, (w == 0) ? 1 : 0);
    check("arready_data", data_arready, (w == 1) ? 1 : 0);
    check("arvalid_in_idle", mem_arvalid, 0);
    step();
    req[w] = 0;
    if (w == 0) inst_arvalid = 1'b0; else data_arvalid = 1'b0;
    for (int i = 0; i <= ar_delay; i++) begin
      mem_arready = (i == ar_delay);
      #1;
      check("mem_arvalid", mem_arvalid, 1);
      check("mem_araddr", mem_araddr, addr[w]);
      check("mem_arlen", mem_arlen, len[w]);
      check("grant_data", grant_data, w);
      check("no_arready_busy", {inst_arready, data_arready}, 0);
      step();
    end
    mem_arready = 1'b0;
    sent = 0; cyc = 0; aborted = 0;
    while (sent < nb[w] && cyc < 4 * nb[w] + 16) begin
      d = $urandom; rs = 2'($urandom);
      lastb = (sent == nb[w] - 1);
      rr = toggle ? (cyc % 2 == 0) : 1'b1;
      mem_rvalid = 1'b1; mem_rdata = d; mem_rresp = rs; mem_rlast = lastb;
      if (w == 0) begin inst_rready = rr; data_rready = 1'($urandom); end
      else        begin data_rready = rr; inst_rready = 1'($urandom); end
      #1;
      check("mem_rready", mem_rready, rr);
      check("no_arready_data", {inst_arready, data_arready}, 0);
      if (w == 0) begin
        check("inst_rbeat", {inst_rvalid, inst_rlast, inst_rresp, inst_rdata}, {1'b1, lastb, rs, d});
        check("data_quiet", {data_rvalid, data_rlast, data_rresp, data_rdata}, 0);
      end else begin
        check("data_rbeat", {data_rvalid, data_rlast, data_rresp, data_rdata}, {1'b1, lastb, rs, d});
        check("inst_quiet", {inst_rvalid, inst_rlast, inst_rresp, inst_rdata}, 0);
      end
      if (rr) begin
        // Error rule: rlast must land exactly on beat index arlen.
        if (lastb != (sent == int'(len[w]))) m_err = 1;
        sent++;
      end
      if (abort_at >= 0 && sent == abort_at) begin
        aborted = 1;
        break;
      end
      step();
      cyc++;
      check("len_err", len_err, m_err);
    end
    if (aborted) begin
      system_reset = 1'b1;
      inst_arvalid = 1'b0; data_arvalid = 1'b0;
      @(posedge system_clk);
      check_reset_outputs("mid_reset");
      system_reset = 1'b0;
      drive_idle();
      m_prio = 0; m_err = 0;
      step();
    end else begin
      check("beats_forwarded", sent, nb[w]);
      m_prio = 1 - w;
    end
    mem_rvalid = 1'b0; mem_rlast = 1'b0;
  endtask

  task automatic set_req(input int m, input logic [31:0] a, input logic [7:0] l, input int n);
    req[m] = 1; addr[m] = a; len[m] = l; nb[m] = n;
  endtask

  initial begin
    addr[0] = '0; addr[1] = '0; len[0] = '0; len[1] = '0; nb[0] = 1; nb[1] = 1;
    do_reset();
    check("rst_arready", {inst_arready, data_arready}, 0);
    check_reset_outputs("rst");

    // Single inst burst
    set_req(0, 32'h1000, 8'd3, 4);
    burst(0, 0, -1);
    check("single_len_err", len_err, 0);

    // Simultaneous requests from reset: inst, data, inst, data
    do_reset();
    set_req(0, 32'h2000, 8'd1, 2); set_req(1, 32'h3000, 8'd2, 3);
    burst(0, 0, -1);
    check("rr_first_inst", grant_data, 0);
    burst(0, 0, -1);
    check("rr_then_data", grant_data, 1);
    set_req(0, 32'h2100, 8'd0, 1); set_req(1, 32'h3100, 8'd3, 4);
    burst(1, 0, -1);
    burst(0, 0, -1);

    // Backpressure: toggling rready, delayed AR acceptance
    set_req(0, 32'h4000, 8'd5, 6);
    burst(3, 1, -1);

    // Early rlast, then a normal burst
    set_req(0, 32'h5000, 8'd3, 3);
    burst(0, 0, -1);
    check("early_err", len_err, 1);
    set_req(1, 32'h5100, 8'd1, 2);
    burst(0, 0, -1);
    check("early_sticky", len_err, 1);

    // Late rlast
    do_reset();
    set_req(0, 32'h6000, 8'd0, 3);
    burst(0, 0, -1);
    check("late_err", len_err, 1);

    // Reset mid-burst, then a data request
    set_req(0, 32'h7000, 8'd3, 4);
    burst(0, 0, 1);
    set_req(1, 32'h7100, 8'd2, 3);
    burst(0, 0, -1);
    check("post_reset_err", len_err, 0);

    // Random traffic
    for (int it = 0; it < 40; it++) begin
      for (int m = 0; m < 2; m++) begin
        if (!req[m] && ($urandom_range(0, 2) != 0))
          set_req(m, $urandom, 8'($urandom_range(0, 6)),
                  ($urandom_range(0, 4) == 0) ? $urandom_range(1, 8) : -1);
        if (req[m] && nb[m] < 0) nb[m] = int'(len[m]) + 1;
      end
      if (!req[0] && !req[1]) set_req(it % 2, $urandom, 8'd2, 3);
      burst($urandom_range(0, 3), 1'($urandom), -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
